// File: rtl/stream_merge_pkg.sv
// rtl/stream_merge_pkg.sv - shared constants, arbiter state encoding and line counter helper
//
// Purpose : Default virtual-channel tdest tags, arbiter FSM encoding and the
//           per-channel line counter update rule used by stream_merge.
// Ports   : none (package)

package stream_merge_pkg;

  localparam logic [9:0] VC0_DEST_DEFAULT = 10'h1e2;
  localparam logic [9:0] VC1_DEST_DEFAULT = 10'h1e3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_e;

  // SOF together with EOL means a one-beat line, so the count restarts at 1.
  function automatic logic [15:0] line_cnt_next(input logic [15:0] cnt,
                                                input logic        sof,
                                                input logic        eol);
    logic [15:0] nxt;
    nxt = cnt;
    if (sof && eol) begin
      nxt = 16'd1;
    end else if (sof) begin
      nxt = 16'd0;
    end else if (eol) begin
      nxt = cnt + 16'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/stream_merge_if.sv
// rtl/stream_merge_if.sv - stream handshake bundle with master/slave modports
//
// Purpose : Groups one stream channel: tvalid/tready/tdata/tlast/tuser/tdest.
// Ports   : master - drives tvalid, tdata, tlast, tuser, tdest; samples tready
//           slave  - samples tvalid, tdata, tlast, tuser, tdest; drives tready

interface stream_merge_if #(
  parameter int WIDTH       = 16,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 10
);

  logic                   tvalid;
  logic                   tready;
  logic [WIDTH-1:0]       tdata;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;
  logic [TDEST_WIDTH-1:0] tdest;

  modport master (
    output tvalid, tdata, tlast, tuser, tdest,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast, tuser, tdest,
    output tready
  );

endinterface

// File: rtl/stream_merge_axis_out_reg.sv
// rtl/stream_merge_axis_out_reg.sv - single-stage registered stream output (module axis_out_reg)
//
// Purpose : Holds one beat for the merged output. A load replaces the held
//           beat (and may coincide with a drain for full throughput); a drain
//           without a load empties the stage. Payload is frozen while stalled.
// Ports   : aclk, aresetn          clock, synchronous active-low reset
//           load, in_*             beat to capture this cycle
//           out_tready             downstream ready
//           out_tvalid, out_*      registered beat

module axis_out_reg #(
  parameter int WIDTH       = 16,
  parameter int TUSER_WIDTH = 1,
  parameter int TDEST_WIDTH = 10
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   load,
  input  logic [WIDTH-1:0]       in_tdata,
  input  logic                   in_tlast,
  input  logic [TUSER_WIDTH-1:0] in_tuser,
  input  logic [TDEST_WIDTH-1:0] in_tdest,
  input  logic                   out_tready,
  output logic                   out_tvalid,
  output logic [WIDTH-1:0]       out_tdata,
  output logic                   out_tlast,
  output logic [TUSER_WIDTH-1:0] out_tuser,
  output logic [TDEST_WIDTH-1:0] out_tdest
);

  logic                   valid_q, valid_d;
  logic [WIDTH-1:0]       data_q,  data_d;
  logic                   last_q,  last_d;
  logic [TUSER_WIDTH-1:0] user_q,  user_d;
  logic [TDEST_WIDTH-1:0] dest_q,  dest_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    user_d  = user_q;
    dest_d  = dest_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = in_tdata;
      last_d  = in_tlast;
      user_d  = in_tuser;
      dest_d  = in_tdest;
    end else if (out_tready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      user_q  <= user_d;
      dest_q  <= dest_d;
    end
  end

  assign out_tvalid = valid_q;
  assign out_tdata  = data_q;
  assign out_tlast  = last_q;
  assign out_tuser  = user_q;
  assign out_tdest  = dest_q;

endmodule

// File: rtl/stream_merge.sv
// rtl/stream_merge.sv - two-input packet-atomic stream merge with tdest tagging
//
// Purpose : Arbitrates two input streams onto one registered output at line
//           granularity. A grant lasts until the tlast beat is accepted, then
//           the arbiter passes through IDLE (one bubble per line). When both
//           inputs wait, the channel not granted last wins. Each beat is tagged
//           with VC0_DEST / VC1_DEST on tdest.
//           Optional macro STREAM_MERGE_LINE_CNT_EN enables per-channel line
//           counters (SOF on tuser[0] clears, tlast increments); otherwise the
//           counter outputs are tied to 0.
// Ports   : aclk, aresetn        clock, synchronous active-low reset
//           s0_axis, s1_axis     input channels (slave modport)
//           m_axis               merged output (master modport)
//           line_cnt0, line_cnt1 per-channel line counters

module stream_merge
  import stream_merge_pkg::*;
#(
  parameter int                     WIDTH       = 16,
  parameter int                     TUSER_WIDTH = 1,
  parameter int                     TDEST_WIDTH = 10,
  parameter logic [TDEST_WIDTH-1:0] VC0_DEST    = TDEST_WIDTH'(VC0_DEST_DEFAULT),
  parameter logic [TDEST_WIDTH-1:0] VC1_DEST    = TDEST_WIDTH'(VC1_DEST_DEFAULT)
) (
  input  logic          aclk,
  input  logic          aresetn,
  stream_merge_if.slave  s0_axis,
  stream_merge_if.slave  s1_axis,
  stream_merge_if.master m_axis,
  output logic [15:0]   line_cnt0,
  output logic [15:0]   line_cnt1
);

  arb_state_e state_q, state_d;
  // 1 = channel 1 was granted most recently; resets to 1 so channel 0 wins first.
  logic       last_grant_q, last_grant_d;

  logic                   m_valid;
  logic                   s0_rdy, s1_rdy;
  logic                   acc0, acc1;
  logic                   load;
  logic [WIDTH-1:0]       ld_data;
  logic                   ld_last;
  logic [TUSER_WIDTH-1:0] ld_user;
  logic [TDEST_WIDTH-1:0] ld_dest;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s0_rdy       = 1'b0;
    s1_rdy       = 1'b0;
    case (state_q)
      IDLE: begin
        if (s0_axis.tvalid && s1_axis.tvalid) begin
          if (last_grant_q) begin
            state_d      = GRANT0;
            last_grant_d = 1'b0;
          end else begin
            state_d      = GRANT1;
            last_grant_d = 1'b1;
          end
        end else if (s0_axis.tvalid) begin
          state_d      = GRANT0;
          last_grant_d = 1'b0;
        end else if (s1_axis.tvalid) begin
          state_d      = GRANT1;
          last_grant_d = 1'b1;
        end
      end
      GRANT0: begin
        // Accept when the output stage is empty or draining this cycle.
        s0_rdy = ~m_valid | m_axis.tready;
        if (s0_rdy && s0_axis.tvalid && s0_axis.tlast) begin
          state_d = IDLE;
        end
      end
      GRANT1: begin
        s1_rdy = ~m_valid | m_axis.tready;
        if (s1_rdy && s1_axis.tvalid && s1_axis.tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign s0_axis.tready = s0_rdy;
  assign s1_axis.tready = s1_rdy;

  assign acc0    = s0_rdy & s0_axis.tvalid;
  assign acc1    = s1_rdy & s1_axis.tvalid;
  assign load    = acc0 | acc1;
  assign ld_data = acc1 ? s1_axis.tdata : s0_axis.tdata;
  assign ld_last = acc1 ? s1_axis.tlast : s0_axis.tlast;
  assign ld_user = acc1 ? s1_axis.tuser : s0_axis.tuser;
  assign ld_dest = acc1 ? VC1_DEST : VC0_DEST;

  axis_out_reg #(
    .WIDTH      (WIDTH),
    .TUSER_WIDTH(TUSER_WIDTH),
    .TDEST_WIDTH(TDEST_WIDTH)
  ) u_out_reg (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .load      (load),
    .in_tdata  (ld_data),
    .in_tlast  (ld_last),
    .in_tuser  (ld_user),
    .in_tdest  (ld_dest),
    .out_tready(m_axis.tready),
    .out_tvalid(m_valid),
    .out_tdata (m_axis.tdata),
    .out_tlast (m_axis.tlast),
    .out_tuser (m_axis.tuser),
    .out_tdest (m_axis.tdest)
  );

  assign m_axis.tvalid = m_valid;

`ifdef STREAM_MERGE_LINE_CNT_EN
  logic [15:0] line_cnt0_q, line_cnt0_d;
  logic [15:0] line_cnt1_q, line_cnt1_d;

  always_comb begin
    line_cnt0_d = line_cnt0_q;
    line_cnt1_d = line_cnt1_q;
    if (acc0) begin
      line_cnt0_d = line_cnt_next(line_cnt0_q, s0_axis.tuser[0], s0_axis.tlast);
    end
    if (acc1) begin
      line_cnt1_d = line_cnt_next(line_cnt1_q, s1_axis.tuser[0], s1_axis.tlast);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      line_cnt0_q <= 16'd0;
      line_cnt1_q <= 16'd0;
    end else begin
      line_cnt0_q <= line_cnt0_d;
      line_cnt1_q <= line_cnt1_d;
    end
  end

  assign line_cnt0 = line_cnt0_q;
  assign line_cnt1 = line_cnt1_q;
`else
  assign line_cnt0 = 16'd0;
  assign line_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_stream_merge.sv
// tb/tb_stream_merge.sv - self-checking bench for stream_merge (honours STREAM_MERGE_LINE_CNT_EN)

module tb_stream_merge;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

`ifdef STREAM_MERGE_LINE_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic [15:0] line_cnt0, line_cnt1;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  stream_merge_if #(.WIDTH(16), .TUSER_WIDTH(1), .TDEST_WIDTH(10)) s0_if ();
  stream_merge_if #(.WIDTH(16), .TUSER_WIDTH(1), .TDEST_WIDTH(10)) s1_if ();
  stream_merge_if #(.WIDTH(16), .TUSER_WIDTH(1), .TDEST_WIDTH(10)) m_if ();

  stream_merge dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .s0_axis  (s0_if),
    .s1_axis  (s1_if),
    .m_axis   (m_if),
    .line_cnt0(line_cnt0),
    .line_cnt1(line_cnt1)
  );

  typedef struct {
    bit          rst;
    bit          s0v;
    logic [15:0] s0d;
    bit          s0l;
    bit          s0u;
    bit          s1v;
    logic [15:0] s1d;
    bit          s1l;
    bit          s1u;
    bit          mrdy;
    bit          e_s0r;
    bit          e_s1r;
    bit          e_mv;
    logic [15:0] e_md;
    bit          e_ml;
    bit          e_mu;
    logic [9:0]  e_dest;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic        l;
    logic        u;
    logic [9:0]  dest;
  } beat_t;

  vec_t  tbl [0:21];
  beat_t exp_q [$];
  bit    mon_en = 1'b0;
  bit    stall_prev = 1'b0;
  logic [15:0] held_d;

  function automatic vec_t mk(bit rst, bit s0v, logic [15:0] s0d, bit s0l, bit s0u,
                              bit s1v, logic [15:0] s1d, bit s1l, bit s1u, bit mrdy,
                              bit e_s0r, bit e_s1r, bit e_mv, logic [15:0] e_md,
                              bit e_ml, bit e_mu, logic [9:0] e_dest);
    vec_t v;
    v.rst = rst; v.s0v = s0v; v.s0d = s0d; v.s0l = s0l; v.s0u = s0u;
    v.s1v = s1v; v.s1d = s1d; v.s1l = s1l; v.s1u = s1u; v.mrdy = mrdy;
    v.e_s0r = e_s0r; v.e_s1r = e_s1r; v.e_mv = e_mv; v.e_md = e_md;
    v.e_ml = e_ml; v.e_mu = e_mu; v.e_dest = e_dest;
    return v;
  endfunction

  function automatic beat_t bt(logic [15:0] d, logic l, logic u, logic [9:0] dest);
    beat_t b;
    b.d = d; b.l = l; b.u = u; b.dest = dest;
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_inputs();
    s0_if.tvalid = 1'b0; s0_if.tdata = 16'h0; s0_if.tlast = 1'b0; s0_if.tuser = 1'b0; s0_if.tdest = 10'h0;
    s1_if.tvalid = 1'b0; s1_if.tdata = 16'h0; s1_if.tlast = 1'b0; s1_if.tuser = 1'b0; s1_if.tdest = 10'h0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    clear_inputs();
    m_if.tready = 1'b1;
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  // Presents one beat on channel ch and holds it until accepted (bounded wait).
  task automatic send_beat(input int ch, input logic [15:0] d, input logic l, input logic u);
    int n;
    logic rdy;
    n = 0;
    if (ch == 0) begin
      s0_if.tvalid = 1'b1; s0_if.tdata = d; s0_if.tlast = l; s0_if.tuser = u;
    end else begin
      s1_if.tvalid = 1'b1; s1_if.tdata = d; s1_if.tlast = l; s1_if.tuser = u;
    end
    @(negedge aclk);
    rdy = (ch == 0) ? s0_if.tready : s1_if.tready;
    while (!rdy && n < 200) begin
      @(negedge aclk);
      rdy = (ch == 0) ? s0_if.tready : s1_if.tready;
      n++;
    end
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL send_timeout ch=%0d actual=not_accepted expected=accepted data=%h", ch, d);
    end
    @(posedge aclk);
    #1;
    if (ch == 0) s0_if.tvalid = 1'b0;
    else         s1_if.tvalid = 1'b0;
  endtask

  // Output scoreboard plus stall-stability and stall-backpressure checks.
  always @(negedge aclk) begin
    if (!mon_en) begin
      stall_prev <= 1'b0;
    end else begin
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL out_beat actual=%h expected=none", m_if.tdata);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          if (m_if.tdata !== e.d || m_if.tlast !== e.l || m_if.tuser !== e.u || m_if.tdest !== e.dest) begin
            failures++;
            $display("FAIL out_beat actual=d%h l%b u%b t%h expected=d%h l%b u%b t%h",
                     m_if.tdata, m_if.tlast, m_if.tuser, m_if.tdest, e.d, e.l, e.u, e.dest);
          end
        end
      end
      if (stall_prev) begin
        checks++;
        if (m_if.tvalid !== 1'b1 || m_if.tdata !== held_d) begin
          failures++;
          $display("FAIL stall_hold actual=v%b d%h expected=v1 d%h", m_if.tvalid, m_if.tdata, held_d);
        end
      end
      if (m_if.tvalid && !m_if.tready) begin
        checks++;
        if (s0_if.tready || s1_if.tready) begin
          failures++;
          $display("FAIL stall_rdy actual=%b%b expected=00", s0_if.tready, s1_if.tready);
        end
      end
      stall_prev <= m_if.tvalid && !m_if.tready;
      held_d     <= m_if.tdata;
    end
  end

  initial begin
    tbl[0]  = mk(L, H,16'h4c02,L,H, L,16'h0000,L,L, H,  L,L,L,16'h0000,L,L,10'h000);
    tbl[1]  = mk(L, H,16'h4c02,L,H, L,16'h0000,L,L, H,  H,L,L,16'h0000,L,L,10'h000);
    tbl[2]  = mk(L, H,16'h0001,L,L, L,16'h0000,L,L, H,  H,L,H,16'h4c02,L,H,10'h1e2);
    tbl[3]  = mk(L, H,16'h0002,L,L, L,16'h0000,L,L, H,  H,L,H,16'h0001,L,L,10'h1e2);
    tbl[4]  = mk(L, H,16'h0003,H,L, L,16'h0000,L,L, H,  H,L,H,16'h0002,L,L,10'h1e2);
    tbl[5]  = mk(L, L,16'h0000,L,L, L,16'h0000,L,L, H,  L,L,H,16'h0003,H,L,10'h1e2);
    tbl[6]  = mk(L, L,16'h0000,L,L, L,16'h0000,L,L, H,  L,L,L,16'h0000,L,L,10'h000);
    tbl[7]  = mk(H, L,16'h0000,L,L, L,16'h0000,L,L, H,  L,L,L,16'h0000,L,L,10'h000);
    tbl[8]  = mk(L, H,16'h0a00,L,H, H,16'h0b00,L,H, H,  L,L,L,16'h0000,L,L,10'h000);
    tbl[9]  = mk(L, H,16'h0a00,L,H, H,16'h0b00,L,H, H,  H,L,L,16'h0000,L,L,10'h000);
    tbl[10] = mk(L, H,16'h0a01,H,L, H,16'h0b00,L,H, H,  H,L,H,16'h0a00,L,H,10'h1e2);
    tbl[11] = mk(L, H,16'h0a02,L,H, H,16'h0b00,L,H, H,  L,L,H,16'h0a01,H,L,10'h1e2);
    tbl[12] = mk(L, H,16'h0a02,L,H, H,16'h0b00,L,H, H,  L,H,L,16'h0000,L,L,10'h000);
    tbl[13] = mk(L, H,16'h0a02,L,H, H,16'h0b01,H,L, H,  L,H,H,16'h0b00,L,H,10'h1e3);
    tbl[14] = mk(L, H,16'h0a02,L,H, H,16'h0b02,L,H, H,  L,L,H,16'h0b01,H,L,10'h1e3);
    tbl[15] = mk(L, H,16'h0a02,L,H, H,16'h0b02,L,H, H,  H,L,L,16'h0000,L,L,10'h000);
    tbl[16] = mk(L, H,16'h0a03,H,L, H,16'h0b02,L,H, H,  H,L,H,16'h0a02,L,H,10'h1e2);
    tbl[17] = mk(L, L,16'h0000,L,L, H,16'h0b02,L,H, H,  L,L,H,16'h0a03,H,L,10'h1e2);
    tbl[18] = mk(L, L,16'h0000,L,L, H,16'h0b02,L,H, H,  L,H,L,16'h0000,L,L,10'h000);
    tbl[19] = mk(L, L,16'h0000,L,L, H,16'h0b03,H,L, H,  L,H,H,16'h0b02,L,H,10'h1e3);
    tbl[20] = mk(L, L,16'h0000,L,L, L,16'h0000,L,L, H,  L,L,H,16'h0b03,H,L,10'h1e3);
    tbl[21] = mk(L, L,16'h0000,L,L, L,16'h0000,L,L, H,  L,L,L,16'h0000,L,L,10'h000);

    clear_inputs();
    m_if.tready = 1'b1;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;

    @(negedge aclk);
    chk("rst_tvalid", 32'(m_if.tvalid), 32'(0));
    chk("rst_tdata",  32'(m_if.tdata),  32'(0));
    chk("rst_tlast",  32'(m_if.tlast),  32'(0));
    chk("rst_tuser",  32'(m_if.tuser),  32'(0));
    chk("rst_tdest",  32'(m_if.tdest),  32'(0));
    chk("rst_cnt0",   32'(line_cnt0),   32'(0));
    chk("rst_cnt1",   32'(line_cnt1),   32'(0));
    chk("rst_rdy",    32'({s0_if.tready, s1_if.tready}), 32'(0));
    tick();

    // Cycle-accurate vectors: s0-only line, then reset and alternating lines.
    for (int i = 0; i < 22; i++) begin
      aresetn       = ~tbl[i].rst;
      s0_if.tvalid  = tbl[i].s0v; s0_if.tdata = tbl[i].s0d; s0_if.tlast = tbl[i].s0l; s0_if.tuser = tbl[i].s0u;
      s1_if.tvalid  = tbl[i].s1v; s1_if.tdata = tbl[i].s1d; s1_if.tlast = tbl[i].s1l; s1_if.tuser = tbl[i].s1u;
      m_if.tready   = tbl[i].mrdy;
      @(negedge aclk);
      chk($sformatf("v%0d_s0_tready", i), 32'(s0_if.tready), 32'(tbl[i].e_s0r));
      chk($sformatf("v%0d_s1_tready", i), 32'(s1_if.tready), 32'(tbl[i].e_s1r));
      chk($sformatf("v%0d_m_tvalid", i),  32'(m_if.tvalid),  32'(tbl[i].e_mv));
      if (tbl[i].e_mv) begin
        chk($sformatf("v%0d_m_tdata", i), 32'(m_if.tdata), 32'(tbl[i].e_md));
        chk($sformatf("v%0d_m_tlast", i), 32'(m_if.tlast), 32'(tbl[i].e_ml));
        chk($sformatf("v%0d_m_tuser", i), 32'(m_if.tuser), 32'(tbl[i].e_mu));
        chk($sformatf("v%0d_m_tdest", i), 32'(m_if.tdest), 32'(tbl[i].e_dest));
      end
      if (i == 6) begin
        chk("cnt0_after_line", 32'(line_cnt0), CNT_EN ? 32'(1) : 32'(0));
      end
      tick();
    end
    aresetn = 1'b1;

    // Backpressure: downstream stalls 5 cycles mid-packet.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      exp_q.push_back(bt(16'h0e00 + 16'(k), (k == 5), (k == 0), 10'h1e2));
    end
    mon_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 6; k++) send_beat(0, 16'h0e00 + 16'(k), (k == 5), (k == 0));
      end
      begin
        repeat (4) tick();
        m_if.tready = 1'b0;
        repeat (5) tick();
        m_if.tready = 1'b1;
      end
    join
    repeat (3) tick();
    chk("bp_all_beats_out", 32'(exp_q.size()), 32'(0));

    // s1 pauses mid-line while s0 waits: s0 must not interleave.
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(bt(16'h0f00 + 16'(k), (k == 3), (k == 0), 10'h1e3));
    for (int k = 0; k < 2; k++) exp_q.push_back(bt(16'h0c00 + 16'(k), (k == 1), (k == 0), 10'h1e2));
    mon_en = 1'b1;
    fork
      begin
        send_beat(1, 16'h0f00, 1'b0, 1'b1);
        send_beat(1, 16'h0f01, 1'b0, 1'b0);
        repeat (3) tick();
        send_beat(1, 16'h0f02, 1'b0, 1'b0);
        send_beat(1, 16'h0f03, 1'b1, 1'b0);
      end
      begin
        repeat (2) tick();
        send_beat(0, 16'h0c00, 1'b0, 1'b1);
        send_beat(0, 16'h0c01, 1'b1, 1'b0);
      end
    join
    repeat (3) tick();
    chk("gap_all_beats_out", 32'(exp_q.size()), 32'(0));

    // Line counter on channel 1: three lines, then an SOF beat without tlast.
    do_reset();
    for (int ln = 0; ln < 3; ln++) begin
      send_beat(1, 16'h0d00 + 16'(ln), 1'b0, (ln == 0));
      send_beat(1, 16'h0d10 + 16'(ln), 1'b1, 1'b0);
    end
    @(negedge aclk);
    chk("cnt1_three_lines", 32'(line_cnt1), CNT_EN ? 32'(3) : 32'(0));
    chk("cnt0_untouched",   32'(line_cnt0), 32'(0));
    tick();
    send_beat(1, 16'h0d20, 1'b0, 1'b1);
    @(negedge aclk);
    chk("cnt1_sof_clear", 32'(line_cnt1), 32'(0));
    tick();
    send_beat(1, 16'h0d21, 1'b1, 1'b0);
    @(negedge aclk);
    chk("cnt1_after_sof_line", 32'(line_cnt1), CNT_EN ? 32'(1) : 32'(0));
    tick();

    // Reset during beat 2 of a 4-beat ch1 packet.
    do_reset();
    s1_if.tvalid = 1'b1; s1_if.tdata = 16'h0c00; s1_if.tlast = 1'b0; s1_if.tuser = 1'b1;
    tick();
    tick();
    s1_if.tdata = 16'h0c01; s1_if.tuser = 1'b0;
    tick();
    s1_if.tdata = 16'h0c02;
    s0_if.tvalid = 1'b1; s0_if.tdata = 16'h0d00; s0_if.tlast = 1'b0; s0_if.tuser = 1'b1;
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rstmid_tvalid_after", 32'(m_if.tvalid), 32'(0));
    chk("rstmid_idle_rdy",     32'({s0_if.tready, s1_if.tready}), 32'(0));
    tick();
    @(negedge aclk);
    chk("rstmid_grant_ch0", 32'({s0_if.tready, s1_if.tready}), 32'(2));
    tick();
    @(negedge aclk);
    chk("rstmid_first_tvalid", 32'(m_if.tvalid), 32'(1));
    chk("rstmid_first_tdata",  32'(m_if.tdata),  32'(16'h0d00));
    chk("rstmid_first_tdest",  32'(m_if.tdest),  32'(10'h1e2));
    tick();
    clear_inputs();
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
